// File: rtl/cam_init_pkg.sv
// rtl/cam_init_pkg.sv - shared types, state encoding and default sensor table for camera bring-up
package cam_init_pkg;

    typedef enum logic [1:0] {
        OP_END     = 2'b00,
        OP_WRITE   = 2'b01,
        OP_DELAY   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    // A DELAY entry reuses the low 16 bits ({reg_addr[7:0], data}) as its tick count
    typedef struct packed {
        op_e         op;
        logic [5:0]  rsvd;
        logic [15:0] reg_addr;
        logic [7:0]  data;
    } tbl_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_FETCH,
        ST_DECODE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_RETRY,
        ST_DLY,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [31:0] CAM_W_SW_RESET  = 32'h4001_0301;
    localparam logic [31:0] CAM_D_RESET_2   = 32'h8000_0002;
    localparam logic [31:0] CAM_W_STREAM_ON = 32'h4001_0001;
    localparam logic [31:0] CAM_END         = 32'h0000_0000;

    function automatic logic [31:0] tbl_wr(input logic [15:0] addr, input logic [7:0] data);
        return {OP_WRITE, 6'd0, addr, data};
    endfunction

    function automatic logic [31:0] tbl_dly(input logic [15:0] ticks);
        return {OP_DELAY, 14'd0, ticks};
    endfunction

    function automatic logic [31:0] cam_tbl_word(input logic [31:0] idx);
        case (idx)
            32'd0:   return CAM_W_SW_RESET;
            32'd1:   return CAM_D_RESET_2;
            32'd2:   return CAM_W_STREAM_ON;
            default: return CAM_END;
        endcase
    endfunction

endpackage

// File: rtl/cam_init_rom.sv
// rtl/cam_init_rom.sv - synchronous register-table ROM, data one cycle after address
module cam_init_rom
    import cam_init_pkg::*;
#(
    parameter int TBL_AW = 8
) (
    input  logic              clk_100,
    input  logic              srst0,
    input  logic [TBL_AW-1:0] tbl_addr,
    output logic [31:0]       tbl_data
);

    always_ff @(posedge clk_100 or posedge srst0) begin
        if (srst0) begin
            tbl_data <= '0;
        end else begin
            tbl_data <= cam_tbl_word(32'(tbl_addr));
        end
    end

endmodule

// File: rtl/cam_init_seq.sv
// rtl/cam_init_seq.sv - camera bring-up sequencer: walks the register table and drives I2C writes
module cam_init_seq
    import cam_init_pkg::*;
#(
    parameter int          TBL_AW        = 8,
    parameter int          STARTUP_TICKS = 4000,
    parameter int          MAX_RETRY     = 3,
    parameter logic [6:0]  DEV_ADDR      = 7'h10
) (
    input  logic              clk_100,
    input  logic              srst0,
    input  logic              strobe_400kHz,
    input  logic              cam_en,
    input  logic              restart,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    output logic              i2c_req_valid,
    input  logic              i2c_req_ready,
    output logic [6:0]        i2c_dev_addr,
    output logic [15:0]       i2c_reg_addr,
    output logic [7:0]        i2c_reg_data,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_err,
    output logic [TBL_AW-1:0] err_index
);

    localparam logic [TBL_AW-1:0] LAST_IDX     = '1;
    localparam logic [TBL_AW-1:0] IDX_ONE      = TBL_AW'(1);
    localparam logic [15:0]       STARTUP_LOAD = 16'(STARTUP_TICKS);
    localparam logic [3:0]        RETRY_LIMIT  = 4'(MAX_RETRY);

    state_e            state_q, state_d;
    logic [TBL_AW-1:0] index_q, index_d;
    logic [TBL_AW-1:0] err_index_q, err_index_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [3:0]        retry_q, retry_d;
    logic [15:0]       reg_addr_q, reg_addr_d;
    logic [7:0]        reg_data_q, reg_data_d;
    logic              adv;
    tbl_entry_t        entry;
    logic              unused_rsvd;

    assign entry       = tbl_entry_t'(tbl_data);
    assign unused_rsvd = ^entry.rsvd;

    always_ff @(posedge clk_100 or posedge srst0) begin
        if (srst0) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            err_index_q <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            err_index_q <= err_index_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        err_index_d = err_index_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        adv         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cam_en) begin
                    state_d = ST_STARTUP;
                    cnt_d   = STARTUP_LOAD;
                    index_d = '0;
                    retry_d = '0;
                end
            end
            ST_STARTUP: begin
                if (strobe_400kHz) begin
                    if (cnt_q <= 16'd1) state_d = ST_FETCH;
                    else                cnt_d   = cnt_q - 16'd1;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (entry.op)
                    OP_END: state_d = ST_DONE;
                    OP_WRITE: begin
                        reg_addr_d = entry.reg_addr;
                        reg_data_d = entry.data;
                        state_d    = ST_REQ;
                    end
                    OP_DELAY: begin
                        cnt_d = {entry.reg_addr[7:0], entry.data};
                        if (cnt_d == 16'd0) adv     = 1'b1;
                        else                state_d = ST_DLY;
                    end
                    OP_ILLEGAL: begin
                        state_d     = ST_ERROR;
                        err_index_d = index_q;
                    end
                endcase
            end
            ST_REQ: if (i2c_req_ready) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        adv = 1'b1;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        if (retry_d >= RETRY_LIMIT) begin
                            state_d     = ST_ERROR;
                            err_index_d = index_q;
                        end else begin
                            state_d = ST_RETRY;
                        end
                    end
                end
            end
            ST_RETRY: if (strobe_400kHz) state_d = ST_REQ;
            ST_DLY: begin
                if (strobe_400kHz) begin
                    if (cnt_q <= 16'd1) adv   = 1'b1;
                    else                cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart && cam_en) begin
                    state_d     = ST_STARTUP;
                    cnt_d       = STARTUP_LOAD;
                    index_d     = '0;
                    retry_d     = '0;
                    err_index_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The last table slot finishes the sequence instead of wrapping back to entry 0
        if (adv) begin
            retry_d = '0;
            if (index_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                index_d = index_q + IDX_ONE;
                state_d = ST_FETCH;
            end
        end

        // An in-flight I2C write is allowed to finish before honouring the enable drop
        if (!cam_en && state_q != ST_REQ && (state_q != ST_WAIT_ACK || i2c_done)) begin
            state_d     = ST_IDLE;
            index_d     = '0;
            err_index_d = '0;
            retry_d     = '0;
            cnt_d       = '0;
        end
    end

    assign tbl_addr      = index_q;
    assign i2c_req_valid = (state_q == ST_REQ);
    assign i2c_dev_addr  = DEV_ADDR;
    assign i2c_reg_addr  = reg_addr_q;
    assign i2c_reg_data  = reg_data_q;
    assign init_busy     = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    assign init_done     = (state_q == ST_DONE);
    assign init_err      = (state_q == ST_ERROR);
    assign err_index     = err_index_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// tb/tb_cam_init_seq.sv - randomized bench for cam_init_seq against a table-walk reference model
module tb_cam_init_seq;
    import cam_init_pkg::*;

    localparam int TBL_AW    = 8;
    localparam int DEPTH     = 256;
    localparam int STARTUP   = 6;
    localparam int MAX_RETRY = 3;
    localparam int STB_DIV   = 5;
    localparam int RUN_LIMIT = 20000;

    logic              clk_100;
    logic              srst0;
    logic              strobe_400kHz;
    logic              cam_en;
    logic              restart;
    logic [TBL_AW-1:0] tbl_addr;
    logic [31:0]       tbl_data;
    logic              i2c_req_valid;
    logic              i2c_req_ready;
    logic [6:0]        i2c_dev_addr;
    logic [15:0]       i2c_reg_addr;
    logic [7:0]        i2c_reg_data;
    logic              i2c_done;
    logic              i2c_nack;
    logic              init_busy;
    logic              init_done;
    logic              init_err;
    logic [TBL_AW-1:0] err_index;

    cam_init_seq #(
        .TBL_AW       (TBL_AW),
        .STARTUP_TICKS(STARTUP),
        .MAX_RETRY    (MAX_RETRY),
        .DEV_ADDR     (7'h10)
    ) dut (
        .clk_100      (clk_100),
        .srst0        (srst0),
        .strobe_400kHz(strobe_400kHz),
        .cam_en       (cam_en),
        .restart      (restart),
        .tbl_addr     (tbl_addr),
        .tbl_data     (tbl_data),
        .i2c_req_valid(i2c_req_valid),
        .i2c_req_ready(i2c_req_ready),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_reg_data (i2c_reg_data),
        .i2c_done     (i2c_done),
        .i2c_nack     (i2c_nack),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .init_err     (init_err),
        .err_index    (err_index)
    );

    logic [31:0] rom [DEPTH];
    always @(posedge clk_100) tbl_data <= rom[tbl_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk_100 = 1'b0;
        forever #5 clk_100 = ~clk_100;
    end

    // stb_total counts strobes already sampled by a rising edge
    int stb_total = 0;
    initial begin
        int ph;
        ph = 0;
        strobe_400kHz = 1'b0;
        forever begin
            @(posedge clk_100);
            #2;
            if (strobe_400kHz) stb_total++;
            ph = (ph + 1) % STB_DIV;
            strobe_400kHz = (ph == 0);
        end
    end

    logic [23:0] acc_q[$];
    int          req_stb_q[$];
    int          done_stb_q[$];
    bit          nack_bits[$];
    int          force_ready = -1;
    int          force_done  = -1;
    int          n_done      = 0;
    int          stable_bad  = 0;
    int          proto_bad   = 0;

    initial begin
        logic [23:0] w;
        int lat;
        i2c_req_ready = 1'b0;
        i2c_done      = 1'b0;
        i2c_nack      = 1'b0;
        forever begin
            @(negedge clk_100);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (i2c_req_valid && !srst0) begin
                w = {i2c_reg_addr, i2c_reg_data};
                req_stb_q.push_back(stb_total);
                lat = (force_ready >= 0) ? force_ready : int'($urandom_range(0, 3));
                repeat (lat) begin
                    @(negedge clk_100);
                    if (!i2c_req_valid || {i2c_reg_addr, i2c_reg_data} != w) stable_bad++;
                end
                i2c_req_ready = 1'b1;
                @(negedge clk_100);
                i2c_req_ready = 1'b0;
                acc_q.push_back(w);
                lat = (force_done >= 0) ? force_done : int'($urandom_range(0, 4));
                repeat (lat) begin
                    if (i2c_req_valid) proto_bad++;
                    @(negedge clk_100);
                end
                if (i2c_req_valid) proto_bad++;
                i2c_done = 1'b1;
                i2c_nack = (nack_bits.size() > 0) ? nack_bits.pop_front() : 1'b0;
                done_stb_q.push_back(stb_total);
                n_done++;
            end
        end
    end

    logic [23:0] exp_q[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_idx;

    // Walks the table as the sequence is described: one attempt per planned NACK bit
    task automatic build_model();
        bit          plan[$];
        bit          nk;
        int          idx;
        int          tries;
        logic [31:0] e;
        plan = nack_bits;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_idx  = 0;
        idx      = 0;
        forever begin
            e = rom[idx];
            if (e[31:30] == 2'b00) begin
                exp_done = 1;
                return;
            end
            if (e[31:30] == 2'b11) begin
                exp_err = 1;
                exp_idx = idx;
                return;
            end
            if (e[31:30] == 2'b01) begin
                tries = 0;
                forever begin
                    exp_q.push_back(e[23:0]);
                    nk = 0;
                    if (plan.size() > 0) nk = plan.pop_front();
                    if (!nk) break;
                    tries++;
                    if (tries == MAX_RETRY) begin
                        exp_err = 1;
                        exp_idx = idx;
                        return;
                    end
                end
            end
            if (idx == DEPTH - 1) begin
                exp_done = 1;
                return;
            end
            idx++;
        end
    endtask

    int s0;

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
    endtask

    task automatic start_run();
        acc_q.delete();
        req_stb_q.delete();
        done_stb_q.delete();
        build_model();
        s0     = stb_total;
        cam_en = 1'b1;
    endtask

    task automatic stop_run();
        cam_en = 1'b0;
        repeat (3) @(negedge clk_100);
    endtask

    task automatic run_and_compare(input string tag);
        int t;
        t = 0;
        while (!(init_done || init_err) && t < RUN_LIMIT) begin
            @(negedge clk_100);
            t++;
        end
        check({tag, "_finished"}, t < RUN_LIMIT, 1);
        repeat (3) @(negedge clk_100);
        check({tag, "_done"}, init_done, exp_done);
        check({tag, "_err"}, init_err, exp_err);
        check({tag, "_busy"}, init_busy, 0);
        if (exp_err) check({tag, "_err_index"}, err_index, exp_idx);
        check({tag, "_n_req"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            check($sformatf("%s_req%0d", tag, i), acc_q[i], exp_q[i]);
    endtask

    int g;
    int t;
    int nd0;

    initial begin
        srst0   = 1'b1;
        cam_en  = 1'b0;
        restart = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk_100);
        srst0 = 1'b0;
        @(negedge clk_100);
        check("rst_valid", i2c_req_valid, 0);
        check("rst_busy", init_busy, 0);
        check("rst_done", init_done, 0);
        check("rst_err", init_err, 0);
        check("rst_err_index", err_index, 0);
        check("rst_dev_addr", i2c_dev_addr, 7'h10);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_reg", {i2c_reg_addr, i2c_reg_data}, 0);

        // nominal bring-up table with timing windows
        clear_rom();
        rom[0] = tbl_wr(16'h0103, 8'h01);
        rom[1] = tbl_dly(16'd2);
        rom[2] = tbl_wr(16'h0100, 8'h01);
        nack_bits.delete();
        start_run();
        run_and_compare("t1");
        if (req_stb_q.size() >= 2 && done_stb_q.size() >= 1) begin
            g = req_stb_q[0] - s0;
            check("t1_startup_gap", g, (g >= STARTUP && g <= STARTUP + 1) ? g : STARTUP);
            g = req_stb_q[1] - done_stb_q[0];
            check("t1_delay_gap", g, (g >= 2 && g <= 3) ? g : 2);
        end else begin
            check("t1_timing_samples", req_stb_q.size(), 2);
        end
        cam_en = 1'b0;
        @(negedge clk_100);
        check("t1_abort_clears_done", init_done, 0);
        stop_run();

        // ready stalled for 10 cycles
        clear_rom();
        rom[0] = tbl_wr(16'h3500, 8'h5A);
        stable_bad  = 0;
        force_ready = 10;
        start_run();
        run_and_compare("t2");
        check("t2_stable", stable_bad, 0);
        force_ready = -1;
        stop_run();

        // two NACKs then ACK, then three NACKs
        clear_rom();
        rom[0] = tbl_wr(16'h0103, 8'h01);
        rom[1] = tbl_dly(16'd2);
        rom[2] = tbl_wr(16'h0100, 8'h01);
        nack_bits = '{1, 1, 0};
        start_run();
        run_and_compare("t3");
        stop_run();
        nack_bits = '{1, 1, 1};
        start_run();
        run_and_compare("t4");
        stop_run();
        nack_bits.delete();

        // illegal op at index 5
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = tbl_wr(16'($urandom), 8'($urandom));
        rom[5] = 32'hC000_0000 | 32'($urandom_range(0, 32'h3FFF_FFFF));
        rom[6] = tbl_wr(16'h1234, 8'h56);
        start_run();
        run_and_compare("t5");
        stop_run();

        // enable drop while counting a delay
        clear_rom();
        rom[0] = tbl_dly(16'd60);
        rom[1] = tbl_wr(16'h0001, 8'h02);
        start_run();
        repeat ((STARTUP + 4) * STB_DIV) @(negedge clk_100);
        check("t6_busy_in_dly", init_busy, 1);
        cam_en = 1'b0;
        @(negedge clk_100);
        check("t6_busy_after_drop", init_busy, 0);
        check("t6_flags", {init_done, init_err, i2c_req_valid}, 0);
        check("t6_no_req", acc_q.size(), 0);
        stop_run();

        // enable drop while a write awaits completion
        clear_rom();
        rom[0] = tbl_wr(16'h0A0B, 8'hC0);
        rom[1] = tbl_wr(16'h0A0C, 8'hC1);
        force_done = 20;
        start_run();
        t = 0;
        while (acc_q.size() < 1 && t < 500) begin
            @(negedge clk_100);
            t++;
        end
        check("t7_accepted", acc_q.size(), 1);
        nd0 = n_done;
        cam_en = 1'b0;
        repeat (3) @(negedge clk_100);
        check("t7_busy_until_done", init_busy, 1);
        t = 0;
        while (n_done == nd0 && t < 100) begin
            @(negedge clk_100);
            t++;
        end
        check("t7_done_seen", n_done, nd0 + 1);
        @(negedge clk_100);
        check("t7_idle_after_done", init_busy, 0);
        repeat (10) @(negedge clk_100);
        check("t7_one_req", acc_q.size(), 1);
        force_done = -1;
        stop_run();

        // randomized mixed tables with random NACKs
        for (int k = 0; k < 4; k++) begin
            int len;
            int r;
            clear_rom();
            len = $urandom_range(4, 14);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 19);
                if (r < 12)      rom[i] = {2'b01, 6'($urandom), 16'($urandom), 8'($urandom)};
                else if (r < 17) rom[i] = {2'b10, 14'($urandom), 16'($urandom_range(0, 3))};
                else if (r < 18) rom[i] = {2'b11, 30'($urandom)};
                else             rom[i] = 32'h0;
            end
            nack_bits.delete();
            for (int i = 0; i < 40; i++) nack_bits.push_back($urandom_range(0, 3) == 0);
            start_run();
            run_and_compare($sformatf("t8_%0d", k));
            stop_run();
        end
        nack_bits.delete();

        // full table without END, then restart
        clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = tbl_wr(16'($urandom), 8'($urandom));
        start_run();
        run_and_compare("t9");
        acc_q.delete();
        build_model();
        restart = 1'b1;
        @(negedge clk_100);
        restart = 1'b0;
        check("t9_restart_clears", {init_done, init_busy}, 2'b01);
        run_and_compare("t9_rerun");
        stop_run();

        // asynchronous reset mid-delay
        clear_rom();
        rom[0] = tbl_dly(16'd60);
        start_run();
        repeat ((STARTUP + 4) * STB_DIV) @(negedge clk_100);
        srst0 = 1'b1;
        #1;
        check("t10_async_reset", {init_busy, init_done, init_err}, 0);
        cam_en = 1'b0;
        repeat (2) @(negedge clk_100);
        srst0 = 1'b0;
        @(negedge clk_100);
        check("t10_idle", init_busy, 0);

        check("proto_single_outstanding", proto_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
